// File: rtl/ddr3_wr_pack.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_wr_pack
// Brief    : Packs a pixel stream into MIG write words. The words are buffered
//            in a first-word-fall-through FIFO that feeds the DDR3 write path.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_wr_pack #(
  parameter int PIX_W  = 16,
  parameter int WORD_W = 128,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 10
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              wr_load,
  input  logic              pix_en,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              frame_end,
  input  logic              app_wdf_wren,
  output logic [WORD_W-1:0] app_wdf_data,
  output logic [CNT_W-1:0]  wfifo_rcount,
  output logic              wfifo_full,
  output logic              wr_ovf
);

  localparam int                  c_lanes     = WORD_W / PIX_W;
  localparam int                  c_lane_w    = $clog2(c_lanes);
  localparam int                  c_addr_w    = $clog2(DEPTH);
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);
  localparam logic [CNT_W-1:0]    c_depth     = CNT_W'(DEPTH);

  // Packer state: lanes already filled for the word under construction
  logic [c_lane_w-1:0] r_pack_cnt;
  logic [WORD_W-1:0]   r_pack_reg;

  // FIFO state; r_head mirrors the RAM entry at r_rd_ptr whenever r_count>0
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_ovf;
  logic [WORD_W-1:0]   r_head;

  logic [WORD_W-1:0]   w_pack_word;
  logic                w_full_word;
  logic                w_flush;
  logic                w_push;
  logic                w_pop_ok;
  logic                w_push_ok;
  logic                w_bypass;
  logic                w_we;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [c_addr_w-1:0] w_rd_ptr_nxt;

  // Current word with this cycle's pixel merged into its lane; unfilled lanes stay zero
  always_comb begin
    w_pack_word = r_pack_reg;
    for (int k = 0; k < c_lanes; k++) begin
      if (pix_en && (r_pack_cnt == c_lane_w'(k))) begin
        w_pack_word[k*PIX_W +: PIX_W] = pix_data;
      end
    end
  end

  // A word leaves the packer when its last lane fills, or on frame_end if it
  // holds anything; a word completed this cycle absorbs the frame_end.
  assign w_full_word  = pix_en && (r_pack_cnt == c_last_lane);
  assign w_flush      = frame_end && !w_full_word && (pix_en || (r_pack_cnt != '0));
  assign w_push       = w_full_word || w_flush;

  // A pop needs a buffered word; a push on a full FIFO only lands if a pop frees a slot.
  assign w_pop_ok     = app_wdf_wren && (r_count != '0);
  assign w_push_ok    = w_push && ((r_count != c_depth) || w_pop_ok);
  assign w_count_nxt  = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
  assign w_rd_ptr_nxt = r_rd_ptr + c_addr_w'(w_pop_ok);
  // The pushed word becomes the new head when nothing else stays buffered.
  assign w_bypass     = w_push_ok && (r_count == CNT_W'(w_pop_ok));
  assign w_we         = w_push_ok && rst_n && !wr_load;

  // Packer lane accumulation and clear after each emitted word
  always_ff @(posedge ui_clk) begin
    if (!rst_n || wr_load) begin
      r_pack_cnt <= '0;
      r_pack_reg <= '0;
    end else if (w_push) begin
      r_pack_cnt <= '0;
      r_pack_reg <= '0;
    end else if (pix_en) begin
      r_pack_cnt <= r_pack_cnt + c_lane_w'(1);
      r_pack_reg <= w_pack_word;
    end
  end

  // Simple dual-port storage write side; no reset so it maps onto block RAM
  always_ff @(posedge ui_clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= w_pack_word;
    end
  end

  // Pointers, count, flags and the registered head-word stage
  always_ff @(posedge ui_clk) begin
    if (!rst_n || wr_load) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_head   <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == c_depth);
      r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
      // Head follows the next read address; it holds its value when the FIFO empties
      if (w_bypass) begin
        r_head <= w_pack_word;
      end else if (w_count_nxt != '0) begin
        r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign app_wdf_data = r_head;
  assign wfifo_rcount = r_count;
  assign wfifo_full   = r_full;
  assign wr_ovf       = r_ovf;

endmodule
`default_nettype wire
